// File: rtl/pga_autorange_if.sv
`default_nettype none
// ============================================================================
//  Module      : pga_autorange_if
//  Description : Signal bundle between the UI / ADC host and the PGA
//                autorange controller.
//                  en           - autorange enable from the UI
//                  manual_gain  - UI gain code, used while en=0
//                  adcdata      - signed 16-bit raw ADC sample
//                  newdata      - one-cycle strobe qualifying adcdata
//                  gain         - PGA gain code driving {A1,A0}
//                  gain_changed - one-cycle pulse when gain changes
//                  ranging      - high while the front end settles
//                  clip         - clip status of the latest sample
//                The slave modport belongs to the controller; the master
//                modport belongs to whoever drives the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pga_autorange_if;
  logic        en;
  logic [1:0]  manual_gain;
  logic [15:0] adcdata;
  logic        newdata;
  logic [1:0]  gain;
  logic        gain_changed;
  logic        ranging;
  logic        clip;

  modport slave (
    input  en, manual_gain, adcdata, newdata,
    output gain, gain_changed, ranging, clip
  );

  modport master (
    output en, manual_gain, adcdata, newdata,
    input  gain, gain_changed, ranging, clip
  );
endinterface
`default_nettype wire

// File: rtl/pga_autorange.sv
`default_nettype none
// ============================================================================
//  Module      : pga_autorange
//  Description : Automatic gain-ranging controller for the input PGA.
//                Measures peak magnitude and clip count of the ADC sample
//                stream over windows of 2^WINDOW_LOG2 samples, steps the
//                2-bit gain code down on repeated clipping or up on a weak
//                signal, then ignores SETTLE_SAMPLES strobes while the analog
//                path settles. With en=0 the UI gain passes straight through.
//  Ports       : CLK36 - 36 MHz system clock
//                rst_n - asynchronous active-low reset
//                bus   - pga_autorange_if.slave (en, manual_gain, adcdata,
//                        newdata in; gain, gain_changed, ranging, clip out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pga_autorange #(
  parameter int          WINDOW_LOG2    = 12,
  parameter int          SETTLE_SAMPLES = 1024,
  parameter logic [15:0] CLIP_LEVEL     = 16'd30720,
  parameter int          CLIP_COUNT     = 4,
  parameter logic [15:0] LOW_LEVEL      = 16'd6000
) (
  input  wire              CLK36,
  input  wire              rst_n,
  pga_autorange_if.slave   bus
);

  localparam int c_CW = $clog2(CLIP_COUNT + 1);
  localparam int c_SW = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [c_CW-1:0] c_CLIP_MAX    = c_CW'(CLIP_COUNT);
  localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_MANUAL  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [1:0]             r_gain,   w_gain_nxt;
  logic [WINDOW_LOG2-1:0] r_win,    w_win_nxt;
  logic [15:0]            r_peak,   w_peak_nxt;
  logic [c_CW-1:0]        r_clips,  w_clips_nxt;
  logic [c_SW-1:0]        r_settle, w_settle_nxt;
  logic                   r_gain_changed;
  logic                   r_ranging;
  logic                   r_clip;

  logic [15:0]            w_mag;
  logic                   w_clip_now;

  // |adcdata|; -32768 has no positive twin, so it saturates to 32767.
  always_comb begin
    w_mag = bus.adcdata;
    if (bus.adcdata[15]) begin
      if (bus.adcdata == 16'h8000) w_mag = 16'h7FFF;
      else                         w_mag = ~bus.adcdata + 16'd1;
    end
  end

  assign w_clip_now = (w_mag >= CLIP_LEVEL);

  // Next-state and datapath decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_gain_nxt   = r_gain;
    w_win_nxt    = r_win;
    w_peak_nxt   = r_peak;
    w_clips_nxt  = r_clips;
    w_settle_nxt = r_settle;

    if (!bus.en) begin
      // Disable overrides every state, including a strobe on the same edge.
      w_state_nxt  = ST_MANUAL;
      w_gain_nxt   = bus.manual_gain;
      w_win_nxt    = '0;
      w_peak_nxt   = '0;
      w_clips_nxt  = '0;
      w_settle_nxt = '0;
    end else begin
      case (r_state)
        ST_MANUAL: begin
          w_state_nxt  = ST_MEASURE;
          w_win_nxt    = '0;
          w_peak_nxt   = '0;
          w_clips_nxt  = '0;
          w_settle_nxt = '0;
        end
        ST_MEASURE: begin
          if (bus.newdata) begin
            if (w_mag > r_peak) w_peak_nxt = w_mag;
            if (w_clip_now && (r_clips < c_CLIP_MAX)) w_clips_nxt = r_clips + 1'b1;
            w_win_nxt = r_win + 1'b1;
            if (&r_win) w_state_nxt = ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          // Strobes during this cycle are deliberately not accumulated.
          if ((r_clips >= c_CLIP_MAX) && (r_gain != 2'd0)) begin
            w_gain_nxt  = r_gain - 2'd1;
            w_state_nxt = ST_SETTLE;
          end else if ((r_peak < LOW_LEVEL) && (r_gain != 2'd3)) begin
            w_gain_nxt  = r_gain + 2'd1;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_MEASURE;
          end
          w_win_nxt    = '0;
          w_peak_nxt   = '0;
          w_clips_nxt  = '0;
          w_settle_nxt = '0;
        end
        ST_SETTLE: begin
          if (bus.newdata) begin
            if (r_settle == c_SETTLE_LAST) begin
              w_state_nxt  = ST_MEASURE;
              w_settle_nxt = '0;
            end else begin
              w_settle_nxt = r_settle + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_MANUAL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK36 or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_MANUAL;
      r_gain         <= 2'd0;
      r_win          <= '0;
      r_peak         <= '0;
      r_clips        <= '0;
      r_settle       <= '0;
      r_gain_changed <= 1'b0;
      r_ranging      <= 1'b0;
      r_clip         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_gain         <= w_gain_nxt;
      r_win          <= w_win_nxt;
      r_peak         <= w_peak_nxt;
      r_clips        <= w_clips_nxt;
      r_settle       <= w_settle_nxt;
      // Compare against the next value so the pulse lines up with the new gain.
      r_gain_changed <= (w_gain_nxt != r_gain);
      r_ranging      <= (w_state_nxt == ST_SETTLE);
      if (bus.newdata) r_clip <= w_clip_now;
    end
  end

  assign bus.gain         = r_gain;
  assign bus.gain_changed = r_gain_changed;
  assign bus.ranging      = r_ranging;
  assign bus.clip         = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_pga_autorange.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pga_autorange
//  Description : Directed self-checking bench for pga_autorange with
//                WINDOW_LOG2=4 and SETTLE_SAMPLES=8. Inputs change on the
//                falling edge; outputs are checked on the falling edge after
//                the rising edge of interest.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pga_autorange;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  pga_autorange_if ifc ();

  pga_autorange #(
    .WINDOW_LOG2    (4),
    .SETTLE_SAMPLES (8)
  ) dut (
    .CLK36 (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #14 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic send(input logic [15:0] v);
    @(negedge clk);
    ifc.adcdata = v;
    ifc.newdata = 1'b1;
    @(negedge clk);
    ifc.newdata = 1'b0;
  endtask

  // Send n samples; with alt set the sign flips on every other sample.
  task automatic send_n(input int n, input logic [15:0] v, input bit alt);
    for (int i = 0; i < n; i++) begin
      if (alt && (i % 2 == 1)) send(16'(-v));
      else                     send(v);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n           = 1'b0;
    ifc.en          = 1'b0;
    ifc.manual_gain = 2'd2;
    ifc.adcdata     = 16'd0;
    ifc.newdata     = 1'b0;

    // ---- 1. reset and manual mode ----
    repeat (3) @(negedge clk);
    chk("rst_gain",    {14'd0, ifc.gain}, 16'd0);
    chk("rst_changed", {15'd0, ifc.gain_changed}, 16'd0);
    chk("rst_ranging", {15'd0, ifc.ranging}, 16'd0);
    chk("rst_clip",    {15'd0, ifc.clip}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("man_gain2",    {14'd0, ifc.gain}, 16'd2);
    chk("man_pulse",    {15'd0, ifc.gain_changed}, 16'd1);
    @(negedge clk);
    chk("man_pulse_end", {15'd0, ifc.gain_changed}, 16'd0);
    ifc.manual_gain = 2'd2;
    @(negedge clk);
    chk("man_same_nopulse", {15'd0, ifc.gain_changed}, 16'd0);
    ifc.manual_gain = 2'd0;
    @(negedge clk);
    chk("man_gain0",    {14'd0, ifc.gain}, 16'd0);
    chk("man_pulse0",   {15'd0, ifc.gain_changed}, 16'd1);
    ifc.en = 1'b1;
    @(negedge clk);
    chk("en_keep_gain", {14'd0, ifc.gain}, 16'd0);

    // ---- 2. up-ranging ----
    send_n(15, 16'd1000, 1'b1);
    chk("up_15_nochange", {14'd0, ifc.gain}, 16'd0);
    send(16'd1000);
    chk("up_decide_cycle", {14'd0, ifc.gain}, 16'd0);
    @(negedge clk);
    chk("up1_gain",    {14'd0, ifc.gain}, 16'd1);
    chk("up1_pulse",   {15'd0, ifc.gain_changed}, 16'd1);
    chk("up1_ranging", {15'd0, ifc.ranging}, 16'd1);
    send_n(7, 16'd32000, 1'b0);
    chk("settle7_ranging", {15'd0, ifc.ranging}, 16'd1);
    chk("settle_clip",     {15'd0, ifc.clip}, 16'd1);
    send(16'd32000);
    chk("settle8_done", {15'd0, ifc.ranging}, 16'd0);
    send_n(16, 16'd1000, 1'b1);
    @(negedge clk);
    chk("up2_gain", {14'd0, ifc.gain}, 16'd2);
    send_n(8, 16'd0, 1'b0);
    send_n(16, 16'd1000, 1'b1);
    @(negedge clk);
    chk("up3_gain",  {14'd0, ifc.gain}, 16'd3);
    chk("up3_pulse", {15'd0, ifc.gain_changed}, 16'd1);
    send_n(8, 16'd0, 1'b0);
    send_n(16, 16'd1000, 1'b1);
    @(negedge clk);
    chk("top_hold_gain",    {14'd0, ifc.gain}, 16'd3);
    chk("top_hold_nopulse", {15'd0, ifc.gain_changed}, 16'd0);
    chk("top_hold_ranging", {15'd0, ifc.ranging}, 16'd0);

    // ---- 3. down-ranging threshold ----
    send_n(4, 16'd32000, 1'b0);
    send_n(12, 16'd100, 1'b0);
    @(negedge clk);
    chk("down_gain",  {14'd0, ifc.gain}, 16'd2);
    chk("down_pulse", {15'd0, ifc.gain_changed}, 16'd1);
    send_n(8, 16'd0, 1'b0);
    send_n(3, 16'd32000, 1'b0);
    send_n(13, 16'd100, 1'b0);
    @(negedge clk);
    chk("three_clips_gain",    {14'd0, ifc.gain}, 16'd2);
    chk("three_clips_nopulse", {15'd0, ifc.gain_changed}, 16'd0);

    // ---- 4. saturation ----
    send(16'h8000);
    chk("sat_clip", {15'd0, ifc.clip}, 16'd1);
    send_n(3, 16'd32000, 1'b0);
    send_n(12, 16'd100, 1'b0);
    @(negedge clk);
    chk("sat_counts_clip", {14'd0, ifc.gain}, 16'd1);
    send_n(8, 16'd0, 1'b0);
    ifc.en          = 1'b0;
    ifc.manual_gain = 2'd0;
    @(negedge clk);
    chk("to_gain0", {14'd0, ifc.gain}, 16'd0);
    ifc.en = 1'b1;
    @(negedge clk);
    send_n(16, 16'h8000, 1'b0);
    @(negedge clk);
    chk("floor_gain",    {14'd0, ifc.gain}, 16'd0);
    chk("floor_nopulse", {15'd0, ifc.gain_changed}, 16'd0);
    chk("floor_ranging", {15'd0, ifc.ranging}, 16'd0);

    // ---- 5. disable mid-window ----
    send_n(10, 16'd1000, 1'b1);
    ifc.en          = 1'b0;
    ifc.manual_gain = 2'd1;
    @(negedge clk);
    chk("dis_gain",  {14'd0, ifc.gain}, 16'd1);
    chk("dis_pulse", {15'd0, ifc.gain_changed}, 16'd1);
    ifc.en = 1'b1;
    @(negedge clk);
    send_n(15, 16'd1000, 1'b1);
    @(negedge clk);
    chk("reen_no_early_decision", {14'd0, ifc.gain}, 16'd1);
    chk("reen_no_ranging",        {15'd0, ifc.ranging}, 16'd0);
    send(16'd1000);
    // Strobe landing in the DECIDE cycle: dropped, but clip still updates.
    ifc.adcdata = 16'd32000;
    ifc.newdata = 1'b1;
    @(negedge clk);
    ifc.newdata = 1'b0;
    chk("reen_gain",       {14'd0, ifc.gain}, 16'd2);
    chk("reen_pulse",      {15'd0, ifc.gain_changed}, 16'd1);
    chk("reen_ranging",    {15'd0, ifc.ranging}, 16'd1);
    chk("decide_clip_upd", {15'd0, ifc.clip}, 16'd1);

    // ---- 6. reset mid-SETTLE ----
    send_n(3, 16'd32000, 1'b0);
    chk("mid_settle_ranging", {15'd0, ifc.ranging}, 16'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gain",    {14'd0, ifc.gain}, 16'd0);
    chk("async_rst_ranging", {15'd0, ifc.ranging}, 16'd0);
    chk("async_rst_clip",    {15'd0, ifc.clip}, 16'd0);
    chk("async_rst_changed", {15'd0, ifc.gain_changed}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
